// File: rtl/axi4l_regfile_pkg.sv
// Shared response codes, FSM state types and the byte-strobe merge helper
// for the AXI4-Lite register-file slave.
package axi4l_regfile_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Sized for the widest legal bus; 32-bit callers zero-extend and truncate.
    function automatic logic [63:0] apply_wstrb(input logic [63:0] old_val,
                                                input logic [63:0] new_val,
                                                input logic [7:0]  strb);
        logic [63:0] res;
        res = old_val;
        for (int k = 0; k < 8; k++) begin
            if (strb[k]) begin
                res[k*8 +: 8] = new_val[k*8 +: 8];
            end else begin
                res[k*8 +: 8] = old_val[k*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4l_regfile_wr_ctrl.sv
// Write-channel controller: AW/W capture in any order, B response, and a
// one-cycle commit (one-hot register select plus data/strobes) to the top.
module axi4l_regfile_wr_ctrl
    import axi4l_regfile_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 8,
    parameter int                  ADDR_WIDTH = 6,
    parameter logic [NUM_REGS-1:0] RO_MASK    = {NUM_REGS{1'b0}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    output logic                    commit_o,
    output logic [NUM_REGS-1:0]     sel_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic [DATA_WIDTH/8-1:0] strb_o
);

    localparam int LSB   = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = ADDR_WIDTH - LSB;

    wr_state_t               state_q, state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    axi_resp_t               bresp_q, bresp_d;

    logic                    aw_hs_s, w_hs_s, done_s, writable_s;
    logic [ADDR_WIDTH-1:0]   eff_addr_s;
    logic [DATA_WIDTH-1:0]   data_s;
    logic [DATA_WIDTH/8-1:0] strb_s;
    logic [IDX_W-1:0]        idx_s;
    logic [NUM_REGS-1:0]     hit_s;
    logic                    unused_s;

    assign aw_hs_s  = awvalid && awready_q;
    assign w_hs_s   = wvalid && wready_q;
    assign unused_s = ^eff_addr_s[LSB-1:0];

    // Select latched or live address/data for the write that may complete now
    always_comb begin
        if (state_q == W_HAVE_AW) begin
            eff_addr_s = awaddr_q;
        end else begin
            eff_addr_s = awaddr;
        end
        if (state_q == W_HAVE_W) begin
            data_s = wdata_q;
            strb_s = wstrb_q;
        end else begin
            data_s = wdata;
            strb_s = wstrb;
        end
        idx_s = eff_addr_s[ADDR_WIDTH-1:LSB];
        hit_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            hit_s[i] = (idx_s == IDX_W'(i));
        end
        writable_s = |(hit_s & ~RO_MASK);
    end

    // Write FSM next state, latches and registered handshake outputs
    always_comb begin
        state_d  = state_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        done_s   = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    done_s  = 1'b1;
                    state_d = W_RESP;
                end else if (aw_hs_s) begin
                    awaddr_d = awaddr;
                    state_d  = W_HAVE_AW;
                end else if (w_hs_s) begin
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    state_d = W_HAVE_W;
                end else begin
                    state_d = W_IDLE;
                end
            end
            W_HAVE_AW: begin
                if (w_hs_s) begin
                    done_s  = 1'b1;
                    state_d = W_RESP;
                end else begin
                    state_d = W_HAVE_AW;
                end
            end
            W_HAVE_W: begin
                if (aw_hs_s) begin
                    done_s  = 1'b1;
                    state_d = W_RESP;
                end else begin
                    state_d = W_HAVE_W;
                end
            end
            W_RESP: begin
                if (bready) begin
                    state_d = W_IDLE;
                end else begin
                    state_d = W_RESP;
                end
            end
            default: begin
                state_d = W_IDLE;
            end
        endcase
        if (done_s) begin
            bresp_d = writable_s ? RESP_OKAY : RESP_SLVERR;
        end else begin
            bresp_d = bresp_q;
        end
        awready_d = (state_d == W_IDLE) || (state_d == W_HAVE_W);
        wready_d  = (state_d == W_IDLE) || (state_d == W_HAVE_AW);
        bvalid_d  = (state_d == W_RESP);
    end

    // Write-channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= W_IDLE;
            awaddr_q  <= {ADDR_WIDTH{1'b0}};
            wdata_q   <= {DATA_WIDTH{1'b0}};
            wstrb_q   <= {(DATA_WIDTH/8){1'b0}};
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    assign awready  = awready_q;
    assign wready   = wready_q;
    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign commit_o = done_s && writable_s;
    assign sel_o    = hit_s;
    assign data_o   = data_s;
    assign strb_o   = strb_s;

endmodule

// File: rtl/axi4l_regfile_slave.sv
// AXI4-Lite register file: owns the register array, read path and access
// pulses; the write channel is handled by axi4l_regfile_wr_ctrl.
module axi4l_regfile_slave
    import axi4l_regfile_pkg::*;
#(
    parameter int                             DATA_WIDTH = 32,
    parameter int                             NUM_REGS   = 8,
    parameter int                             ADDR_WIDTH = 6,
    parameter logic [NUM_REGS-1:0]            RO_MASK    = {NUM_REGS{1'b0}},
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = {(NUM_REGS*DATA_WIDTH){1'b0}}
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [NUM_REGS-1:0]            rd_pulse
);

    localparam int LSB   = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = ADDR_WIDTH - LSB;

    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
    logic [NUM_REGS-1:0]     rd_pulse_q, rd_pulse_d;
    rd_state_t               rd_state_q, rd_state_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    axi_resp_t               rresp_q, rresp_d;

    logic                    wr_commit_s;
    logic [NUM_REGS-1:0]     wr_sel_s;
    logic [DATA_WIDTH-1:0]   wr_data_s;
    logic [DATA_WIDTH/8-1:0] wr_strb_s;
    logic                    ar_hs_s;
    logic [IDX_W-1:0]        rd_idx_s;
    logic [NUM_REGS-1:0]     rd_hit_s;
    logic                    unused_s;

    assign ar_hs_s  = S_AXI_ARVALID && arready_q;
    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[LSB-1:0]};

    axi4l_regfile_wr_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RO_MASK    (RO_MASK)
    ) u_wr_ctrl (
        .clk      (ACLK),
        .rst      (ARESET),
        .awaddr   (S_AXI_AWADDR),
        .awvalid  (S_AXI_AWVALID),
        .awready  (S_AXI_AWREADY),
        .wdata    (S_AXI_WDATA),
        .wstrb    (S_AXI_WSTRB),
        .wvalid   (S_AXI_WVALID),
        .wready   (S_AXI_WREADY),
        .bresp    (S_AXI_BRESP),
        .bvalid   (S_AXI_BVALID),
        .bready   (S_AXI_BREADY),
        .commit_o (wr_commit_s),
        .sel_o    (wr_sel_s),
        .data_o   (wr_data_s),
        .strb_o   (wr_strb_s)
    );

    // Byte-strobed register update and write pulse on commit
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_commit_s && wr_sel_s[i]) begin
                regs_d[i] = DATA_WIDTH'(apply_wstrb(64'(regs_q[i]), 64'(wr_data_s), 8'(wr_strb_s)));
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
        if (wr_commit_s) begin
            wr_pulse_d = wr_sel_s;
        end else begin
            wr_pulse_d = {NUM_REGS{1'b0}};
        end
    end

    // Read FSM; data is sampled from the pre-write register contents
    always_comb begin
        rd_idx_s   = S_AXI_ARADDR[ADDR_WIDTH-1:LSB];
        rd_hit_s   = {NUM_REGS{1'b0}};
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_pulse_d = {NUM_REGS{1'b0}};
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rd_state_d = R_DATA;
                    rdata_d    = {DATA_WIDTH{1'b0}};
                    rresp_d    = RESP_SLVERR;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (rd_idx_s == IDX_W'(i)) begin
                            rd_hit_s[i] = 1'b1;
                            rresp_d     = RESP_OKAY;
                            rdata_d     = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
                        end else begin
                            rd_hit_s[i] = 1'b0;
                        end
                    end
                    rd_pulse_d = rd_hit_s;
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rd_state_d = R_IDLE;
                end else begin
                    rd_state_d = R_DATA;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
            end
        endcase
        arready_d = (rd_state_d == R_IDLE);
        rvalid_d  = (rd_state_d == R_DATA);
    end

    // Register array, read channel and pulse registers
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
            end
            wr_pulse_q <= {NUM_REGS{1'b0}};
            rd_pulse_q <= {NUM_REGS{1'b0}};
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= {DATA_WIDTH{1'b0}};
            rresp_q    <= RESP_OKAY;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_pulse_q <= wr_pulse_d;
            rd_pulse_q <= rd_pulse_d;
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    assign wr_pulse      = wr_pulse_q;
    assign rd_pulse      = rd_pulse_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4l_regfile_slave.sv
// Directed bench for axi4l_regfile_slave with a register-array model and a
// per-cycle compare of reg_out and the access pulses.
module tb_axi4l_regfile_slave;

    localparam logic [255:0] RV = 256'h0000_BEEF << 192;
    localparam logic [7:0]   RO = 8'b1000_0000;

    logic         aclk = 1'b0;
    logic         areset;
    logic [5:0]   awaddr, araddr;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [255:0] reg_out, reg_in;
    logic [7:0]   wr_pulse, rd_pulse;

    logic [31:0]  mregs [8];
    logic [255:0] rv_v;
    logic [7:0]   ro_v;
    logic [7:0]   exp_wr, exp_rd;
    int           total = 0;
    int           bad = 0;

    always #5 aclk = ~aclk;

    axi4l_regfile_slave #(
        .DATA_WIDTH (32),
        .NUM_REGS   (8),
        .ADDR_WIDTH (6),
        .RO_MASK    (RO),
        .RESET_VAL  (RV)
    ) dut (
        .ACLK          (aclk),
        .ARESET        (areset),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (3'b000),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (3'b000),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_out       (reg_out),
        .reg_in        (reg_in),
        .wr_pulse      (wr_pulse),
        .rd_pulse      (rd_pulse)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[i*32 +: 32] = mregs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = rv_v[i*32 +: 32];
    endtask

    // Expected write response and pulse from the register map rules.
    task automatic model_wr_resp(input logic [5:0] a, output logic [1:0] r, output logic [7:0] p);
        int idx;
        idx = int'(a) / 4;
        if (idx >= 8 || ro_v[idx]) begin
            r = 2'b10; p = 8'h00;
        end else begin
            r = 2'b00; p = 8'(1 << idx);
        end
    endtask

    task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a) / 4;
        for (int b = 0; b < 4; b++)
            if (s[b]) mregs[idx][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic model_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r, output logic [7:0] p);
        int idx;
        idx = int'(a) / 4;
        if (idx >= 8) begin
            d = 32'h0; r = 2'b10; p = 8'h00;
        end else begin
            d = ro_v[idx] ? reg_in[idx*32 +: 32] : mregs[idx];
            r = 2'b00;
            p = 8'(1 << idx);
        end
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_at, input int w_at, input int bp, output logic [1:0] got_b);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_hs, w_hs;
        int c = 0;
        logic [1:0] er;
        logic [7:0] ep;
        model_wr_resp(addr, er, ep);
        while (!(aw_done && w_done) && c < 20) begin
            if (c == aw_at) begin awaddr = addr; awvalid = 1'b1; end
            if (c == w_at) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
            chk("bvalid_early", bvalid, 1'b0);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge aclk); #1;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs) begin wvalid = 1'b0; w_done = 1'b1; end
            c++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("wr_handshakes", {aw_done, w_done}, 2'b11);
        chk("bvalid_rise", bvalid, 1'b1);
        chk("bresp", bresp, er);
        got_b = bresp;
        if (er == 2'b00) model_write(addr, data, strb);
        exp_wr = ep;
        for (int i = 0; i < bp; i++) begin
            chk("bp_bvalid", bvalid, 1'b1);
            chk("bp_bresp", bresp, er);
            chk("bp_awready", awready, 1'b0);
            chk("bp_wready", wready, 1'b0);
            @(posedge aclk); #1;
            exp_wr = 8'h00;
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        exp_wr = 8'h00;
        chk("b_done", bvalid, 1'b0);
        chk("awready_back", awready, 1'b1);
    endtask

    task automatic do_read(input logic [5:0] addr, input int bp,
                           output logic [31:0] got_d, output logic [1:0] got_r);
        logic [31:0] ed;
        logic [1:0]  er;
        logic [7:0]  ep;
        int c = 0;
        araddr  = addr;
        arvalid = 1'b1;
        while (!arready && c < 20) begin
            @(posedge aclk); #1;
            c++;
        end
        chk("arready", arready, 1'b1);
        model_read(addr, ed, er, ep);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        exp_rd  = ep;
        chk("rvalid_rise", rvalid, 1'b1);
        chk("rdata", rdata, ed);
        chk("rresp", rresp, er);
        got_d = rdata;
        got_r = rresp;
        for (int i = 0; i < bp; i++) begin
            chk("bp_rvalid", rvalid, 1'b1);
            chk("bp_rdata", rdata, ed);
            chk("bp_arready", arready, 1'b0);
            @(posedge aclk); #1;
            exp_rd = 8'h00;
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        exp_rd = 8'h00;
        chk("r_done", rvalid, 1'b0);
        chk("arready_back", arready, 1'b1);
    endtask

    // Per-cycle comparison of the register outputs and pulses with the model.
    always @(negedge aclk) begin
        chk("reg_out", reg_out, model_flat());
        chk("wr_pulse", wr_pulse, exp_wr);
        chk("rd_pulse", rd_pulse, exp_rd);
        if (areset)
            chk("reset_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}, 41'h0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] gd, gd2;
        logic [1:0]  gr, gr2, gb;
        rv_v    = RV;
        ro_v    = RO;
        reg_in  = {32'hCAFE_F00D, 192'h0, 32'hDEAD_DEAD};
        model_reset();
        exp_wr  = 8'h00;
        exp_rd  = 8'h00;
        areset  = 1'b1;
        awaddr  = 6'h00; awvalid = 1'b0;
        wdata   = 32'h0; wstrb = 4'h0; wvalid = 1'b0;
        bready  = 1'b0;
        araddr  = 6'h00; arvalid = 1'b0; rready = 1'b0;

        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(posedge aclk); #1;
        chk("post_rst_awready", awready, 1'b1);
        chk("post_rst_wready", wready, 1'b1);
        chk("post_rst_arready", arready, 1'b1);
        chk("post_rst_bvalid", bvalid, 1'b0);
        chk("post_rst_rvalid", rvalid, 1'b0);

        do_read(6'h18, 0, gd, gr);
        chk("lit_reset_reg6", gd, 32'h0000_BEEF);

        for (int i = 0; i < 4; i++) do_write(6'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, gb);
        for (int i = 0; i < 4; i++) begin
            do_read(6'(i * 4), 0, gd, gr);
            chk("lit_seq_data", gd, 32'(i + 1));
            chk("lit_seq_resp", gr, 2'b00);
        end

        do_write(6'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, gb);
        do_write(6'h10, 32'h1234_5678, 4'b0101, 0, 0, 0, gb);
        do_read(6'h10, 0, gd, gr);
        chk("lit_strobe", gd, 32'hFF34_FF78);

        do_write(6'h14, 32'h0000_00A1, 4'hF, 3, 0, 0, gb);
        do_write(6'h18, 32'h0000_00A2, 4'hF, 0, 3, 0, gb);
        do_read(6'h14, 0, gd, gr);
        chk("lit_w_first", gd, 32'h0000_00A1);
        do_write(6'h14, 32'h0000_00A3, 4'hF, 0, 0, 0, gb);
        do_read(6'h14, 0, gd, gr);
        chk("lit_together", gd, 32'h0000_00A3);
        do_read(6'h18, 0, gd, gr);
        chk("lit_aw_first", gd, 32'h0000_00A2);
        do_read(6'h0E, 0, gd, gr);
        chk("lit_unaligned", gd, 32'h0000_0004);

        do_write(6'h1C, 32'h1111_1111, 4'hF, 0, 0, 0, gb);
        chk("lit_ro_bresp", gb, 2'b10);
        do_read(6'h1C, 0, gd, gr);
        chk("lit_ro_data", gd, 32'hCAFE_F00D);
        do_read(6'h20, 0, gd, gr);
        chk("lit_oor_data", gd, 32'h0);
        chk("lit_oor_rresp", gr, 2'b10);
        do_write(6'h3C, 32'h2222_2222, 4'hF, 0, 0, 0, gb);
        chk("lit_oor_bresp", gb, 2'b10);

        do_write(6'h00, 32'h0BAD_F00D, 4'hF, 0, 0, 5, gb);
        do_read(6'h00, 5, gd, gr);
        chk("lit_backpressure", gd, 32'h0BAD_F00D);

        fork
            do_write(6'h08, 32'h0000_0055, 4'hF, 0, 0, 0, gb);
            do_read(6'h08, 0, gd2, gr2);
        join
        chk("lit_pre_write_read", gd2, 32'h0000_0003);
        do_read(6'h08, 0, gd, gr);
        chk("lit_post_write_read", gd, 32'h0000_0055);

        awaddr  = 6'h04;
        awvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        chk("aw_captured_awready", awready, 1'b0);
        areset = 1'b1;
        model_reset();
        exp_wr = 8'h00;
        exp_rd = 8'h00;
        repeat (3) begin
            @(posedge aclk); #1;
            chk("rst_mid_bvalid", bvalid, 1'b0);
        end
        areset = 1'b0;
        @(posedge aclk); #1;
        chk("rst2_awready", awready, 1'b1);
        chk("rst2_wready", wready, 1'b1);
        chk("rst2_arready", arready, 1'b1);
        repeat (2) begin
            @(posedge aclk); #1;
            chk("rst2_no_bvalid", bvalid, 1'b0);
        end
        do_read(6'h04, 0, gd, gr);
        chk("lit_rst2_reg1", gd, 32'h0);
        do_write(6'h04, 32'h0000_7777, 4'hF, 0, 0, 0, gb);
        chk("lit_rst2_bresp", gb, 2'b00);
        do_read(6'h04, 0, gd, gr);
        chk("lit_rst2_write", gd, 32'h0000_7777);

        repeat (2) @(posedge aclk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4l_regfile_slave.md
Name: axi4l_regfile_slave

Overview:
- Parametrised AXI4-Lite register-file slave. Next generation of the fixed 4×32-bit user-register slave used in our AXI-VIP-driven IP packages.
- Adds configurable width and depth, byte strobes, per-register read-only status inputs, decode-error responses, and per-register access pulses toward user logic.
- Sits between the AXI interconnect (or the master VIP in the bench) and the IP core's control/status logic.

Parameters:
- DATA_WIDTH, 32: AXI data width; only 32 or 64 are legal.
- NUM_REGS, 8: number of registers; range 1..256.
- ADDR_WIDTH, 6: AXI address width; must be ≥ clog2(NUM_REGS) + clog2(DATA_WIDTH/8).
- RO_MASK, 0 (NUM_REGS bits): bit i = 1 makes register i read-only. Reads return reg_in slice i.
- RESET_VAL, 0 (NUM_REGS×DATA_WIDTH bits): flat vector of per-register reset values.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  asynchronous reset, active-high.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1 / 1  write-address handshake.
- S_AXI_WDATA  in  DATA_WIDTH  write data.
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1 / 1  write-data handshake.
- S_AXI_BRESP  out  2  write response: OKAY = 00, SLVERR = 10.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1 / 1  write-response handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1 / 1  read-address handshake.
- S_AXI_RDATA  out  DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1 / 1  read-data handshake.
- reg_out  out  NUM_REGS×DATA_WIDTH  current value of every register; register i occupies bits [i×DATA_WIDTH +: DATA_WIDTH].
- reg_in  in  NUM_REGS×DATA_WIDTH  status values for read-only registers.
- wr_pulse  out  NUM_REGS  one-cycle strobe on each successful register write.
- rd_pulse  out  NUM_REGS  one-cycle strobe on each read of that register.

Behaviour:
- Reset (asynchronous, ARESET = 1):
  - All VALID and READY outputs go to 0; BRESP, RRESP and RDATA go to 0.
  - wr_pulse and rd_pulse go to 0; reg_out takes RESET_VAL.
  - Pending AW/W latches are cleared.
  - A transaction in flight when reset asserts is discarded and never gets a response.
  - In the first cycle after deassertion, AWREADY, WREADY and ARREADY are 1.
- Address decode:
  - index = addr[ADDR_WIDTH-1 : clog2(DATA_WIDTH/8)]; the low address bits are ignored, so unaligned accesses are not errors.
  - index ≥ NUM_REGS gives SLVERR.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - AWREADY = 1 in W_IDLE and W_HAVE_W. WREADY = 1 in W_IDLE and W_HAVE_AW.
  - AW and W may arrive in either order or in the same cycle; each is latched on its handshake.
  - On the edge where both have been captured, the FSM enters W_RESP and BVALID rises.
  - On that same edge, register[index] is updated: byte k is replaced where WSTRB[k] = 1, other bytes are kept.
  - wr_pulse[index] is high for exactly the first W_RESP cycle.
  - Out-of-range index or RO_MASK[index] = 1: BRESP = SLVERR, no register update, no wr_pulse.
  - BVALID stays high until BREADY, then the FSM returns to W_IDLE. Minimum write is 2 cycles from a simultaneous AW/W handshake to the B handshake.
- Read FSM states: R_IDLE, R_DATA.
  - ARREADY = 1 only in R_IDLE.
  - On the AR handshake, the next edge registers RDATA/RRESP, sets RVALID = 1, and pulses rd_pulse[index] for that one cycle. Latency is 1.
  - RDATA source: RO_MASK[index] = 1 gives reg_in slice; otherwise the register value; out of range gives 0 with SLVERR.
  - RDATA/RRESP hold stable while RVALID = 1 and RREADY = 0.
  - On the RREADY handshake, the FSM returns to R_IDLE. Back-to-back reads run at 1 read per 2 cycles.
- Simultaneous read and write:
  - The read and write channels are independent.
  - A read captured on the same edge as a write to the same register returns the pre-write value.
- BRESP never equals DECERR; EXOKAY is not supported.

Decomposition:
- Package axi4l_regfile_pkg:
  - typedef axi_resp_t (2-bit) with constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
  - Enums wr_state_t and rd_state_t.
  - Function apply_wstrb(old, new, strb).
- Sub-module axi4l_regfile_wr_ctrl: the write FSM plus AW/W latches. It outputs a one-cycle commit, index and strobed data to the top, which owns the register array and the read path.

Test Plan:
- Reset plus sequential writes: write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC. Each gets BRESP = 00 and wr_pulse bits 0..3 pulse once each. Reading the four addresses back returns the same values with RRESP = 00.
- Byte strobes: write 0xFFFFFFFF then write 0x12345678 with WSTRB = 4'b0101 to 0x10. Readback = 0xFF34FF78.
- Channel ordering: W precedes AW by 3 cycles, then the reverse, then both together. All three complete with BVALID one edge after the later handshake. Data is correct in each case.
- Errors and read-only:
  - With RO_MASK = 8'b1000_0000 and reg_in slice 7 = 0xCAFEF00D, write to 0x1C gives SLVERR, no wr_pulse, and readback 0xCAFEF00D.
  - Read of 0x20 (index 8) gives RRESP = 10 and RDATA = 0.
- Backpressure: BREADY and RREADY are held low for 5 cycles. BVALID/RVALID and data stay stable, and AWREADY/ARREADY stay low until the response handshake.
- Reset mid-write: assert ARESET after the AW handshake and before W. BVALID stays 0, reg_out = RESET_VAL, and the next full write succeeds normally.
